uart_tx_buffered: RTL and testbench

//  UART transmitter: counterpart of uart_rx on the same serial link (8N1 default, optional parity, 1 or 2 stop bits).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_buffered.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, bit-period calculation and parity helper.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

    localparam logic [2:0] sIDLE      = 3'd0;
    localparam logic [2:0] sTX_START  = 3'd1;
    localparam logic [2:0] sTX_DATA   = 3'd2;
    localparam logic [2:0] sTX_PARITY = 3'd3;
    localparam logic [2:0] sTX_STOP   = 3'd4;
    localparam logic [2:0] sDONE      = 3'd5;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Even parity when odd=0: the returned bit makes the total count of ones even.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a one-byte holding register feeds a bit-timing FSM
// that shifts frames out LSB-first, so the next byte can be queued mid-frame.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 125_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE),
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iTxByte,
    input  logic       iTxValid,
    output logic       oTxReady,
    output logic       oTxSerial,
    output logic       oTxBusy,
    output logic       oTxDone,
    output logic [2:0] oDbgState
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic              PAR_ODD   = (PARITY_ODD != 0);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1 or 2");
    end

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic [7:0]       r_hold;
    logic             r_hold_full;
    logic             r_serial;
    logic             r_done;

    logic [2:0]       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       w_bit_next;
    logic [7:0]       w_shift_next;
    logic [7:0]       w_data_next;
    logic             w_load;
    logic             w_accept;
    logic             w_cnt_end;
    logic             w_serial_next;

    // Handshake: a byte is taken at a posedge where iTxValid=1 and oTxReady=1.
    // oTxReady comes straight from the holding-register flag, never from iTxValid.
    assign w_accept  = iTxValid && !r_hold_full;
    assign w_cnt_end = (r_cnt == CNT_MAX);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_cnt_end ? '0 : r_cnt + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_load       = 1'b0;
        case (r_state)
            sIDLE, sDONE: begin
                w_cnt_next = '0;
                w_bit_next = '0;
                if (r_hold_full) begin
                    w_load       = 1'b1;
                    w_state_next = sTX_START;
                    w_shift_next = r_hold;
                    w_data_next  = r_hold;
                end else begin
                    w_state_next = sIDLE;
                end
            end
            sTX_START: begin
                if (w_cnt_end) begin
                    w_state_next = sTX_DATA;
                    w_bit_next   = '0;
                end
            end
            sTX_DATA: begin
                if (w_cnt_end) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_bit_next   = '0;
                        w_state_next = (PARITY_EN != 0) ? sTX_PARITY : sTX_STOP;
                    end
                end
            end
            sTX_PARITY: begin
                if (w_cnt_end) begin
                    w_state_next = sTX_STOP;
                    w_bit_next   = '0;
                end
            end
            sTX_STOP: begin
                // r_bit counts stop-bit periods here
                if (w_cnt_end) begin
                    if (r_bit == STOP_LAST) begin
                        w_state_next = sDONE;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = sIDLE;
                w_cnt_next   = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    // Line level is derived from the next state so oTxSerial is a plain register.
    always_comb begin
        w_serial_next = 1'b1;
        case (w_state_next)
            sTX_START:  w_serial_next = 1'b0;
            sTX_DATA:   w_serial_next = w_shift_next[0];
            sTX_PARITY: w_serial_next = calc_parity(w_data_next, PAR_ODD);
            default:    w_serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_state     <= sIDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_serial    <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_data   <= w_data_next;
            r_serial <= w_serial_next;
            r_done   <= (w_state_next == sDONE);
            if (w_load) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold      <= iTxByte;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign oTxReady  = !r_hold_full;
    assign oTxSerial = r_serial;
    assign oTxBusy   = (r_state != sIDLE);
    assign oTxDone   = r_done;
    assign oDbgState = r_state;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: three configurations (8N1, even parity with
// two stop bits, odd parity with one stop bit), each at 8 clocks per bit.
module tb_uart_tx_buffered;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic tx_valid = 1'b0;
    int sel = 0;

    logic v0, v1, v2;
    logic rdy0, rdy1, rdy2, ser0, ser1, ser2, bsy0, bsy1, bsy2, dn0, dn1, dn2;
    logic [2:0] st0, st1, st2;
    logic m_ready, m_ser, m_busy, m_done;
    int m_nbits;

    logic [11:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_pushed = 0;
    int n_abort = 0;
    int done_cnt = 0;
    int cyc = 0;
    int done_cyc = -1000;
    int last_gap = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign v0 = tx_valid && (sel == 0);
    assign v1 = tx_valid && (sel == 1);
    assign v2 = tx_valid && (sel == 2);

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .iClk(clk), .iRst(rst_n), .iTxByte(tx_byte), .iTxValid(v0), .oTxReady(rdy0),
        .oTxSerial(ser0), .oTxBusy(bsy0), .oTxDone(dn0), .oDbgState(st0));
    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .iClk(clk), .iRst(rst_n), .iTxByte(tx_byte), .iTxValid(v1), .oTxReady(rdy1),
        .oTxSerial(ser1), .oTxBusy(bsy1), .oTxDone(dn1), .oDbgState(st1));
    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .iClk(clk), .iRst(rst_n), .iTxByte(tx_byte), .iTxValid(v2), .oTxReady(rdy2),
        .oTxSerial(ser2), .oTxBusy(bsy2), .oTxDone(dn2), .oDbgState(st2));

    always_comb begin
        m_ready = rdy0; m_ser = ser0; m_busy = bsy0; m_done = dn0; m_nbits = 10;
        case (sel)
            1: begin m_ready = rdy1; m_ser = ser1; m_busy = bsy1; m_done = dn1; m_nbits = 12; end
            2: begin m_ready = rdy2; m_ser = ser2; m_busy = bsy2; m_done = dn2; m_nbits = 11; end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input logic [11:0] frame, input logic push);
        int n;
        tx_byte = b;
        tx_valid = 1'b1;
        n = 0;
        while (!m_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            check("send_timeout", 32'd0, 32'd1);
            tx_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (push) begin
                exp_q.push_back(frame);
                n_pushed++;
            end
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_busy) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("drain", {31'd0, (exp_q.size() == 0 && !m_busy)}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {28'd0, m_ser, m_ready, m_busy, m_done}, {28'd0, 4'b1100});
    endtask

    // Monitor: decode each frame cycle by cycle and compare with the scoreboard.
    initial begin : monitor
        logic [11:0] frame;
        logic [11:0] exp_frame;
        logic stable;
        logic aborted;
        forever begin
            @(negedge clk);
            if (rst_n && m_ser === 1'b0) begin
                frame = '0;
                stable = 1'b1;
                aborted = 1'b0;
                last_gap = cyc - done_cyc;
                for (int b = 0; b < m_nbits; b++) begin
                    if (aborted) break;
                    for (int c = 0; c < CPB; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (!m_busy) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (m_done) stable = 1'b0;
                        if (c == 0) frame[b] = m_ser;
                        else if (m_ser !== frame[b]) stable = 1'b0;
                    end
                end
                if (aborted) begin
                    n_abort++;
                end else begin
                    @(negedge clk);
                    check("done_timing", {29'd0, m_done, m_ser, m_busy}, {29'd0, 3'b111});
                    done_cyc = cyc;
                    check("bit_stable", {31'd0, stable}, 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {20'd0, frame}, 32'hFFFF_FFFF);
                    end else begin
                        exp_frame = exp_q.pop_front();
                        check("frame", {20'd0, frame}, {20'd0, exp_frame});
                    end
                end
            end
        end
    end

    always @(negedge clk) if (m_done === 1'b1) done_cnt++;

    initial begin : stimulus
        int n;
        int ok;
        repeat (3) @(negedge clk);
        check_reset_outputs("power_on_reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset while idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("idle_reset");
        check("idle_reset_state", {29'd0, st0}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 0xA5, 8N1
        send_byte(8'hA5, {1'b1, 8'hA5, 1'b0}, 1'b1);
        check("line_idle_at_handshake", {31'd0, m_ser}, 32'd1);
        @(negedge clk);
        check("start_latency", {31'd0, m_ser}, 32'd0);
        wait_drain();

        // Back-to-back 0x00, 0xFF with valid held
        send_byte(8'h00, {1'b1, 8'h00, 1'b0}, 1'b1);
        send_byte(8'hFF, {1'b1, 8'hFF, 1'b0}, 1'b1);
        n = 0;
        while (!m_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("ready_low_cycles", n, 32'd80);
        wait_drain();
        check("b2b_gap", last_gap, 32'd1);

        // Reset during data bit 3, then a clean frame
        send_byte(8'hA5, 12'h000, 1'b0);
        repeat (36) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_line", {30'd0, m_ser, m_busy}, 32'd2);
        send_byte(8'h3C, {1'b1, 8'h3C, 1'b0}, 1'b1);
        wait_drain();

        // Holding register full: 0x22 must wait, 0x11 goes first
        send_byte(8'h55, {1'b1, 8'h55, 1'b0}, 1'b1);
        send_byte(8'h11, {1'b1, 8'h11, 1'b0}, 1'b1);
        tx_byte = 8'h22;
        tx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            if (!m_ready) ok++;
            @(negedge clk);
        end
        check("hold_full_ready_low", ok, 32'd5);
        send_byte(8'h22, {1'b1, 8'h22, 1'b0}, 1'b1);
        wait_drain();

        // Even parity, two stop bits
        sel = 1;
        repeat (2) @(negedge clk);
        send_byte(8'h07, {2'b11, 1'b1, 8'h07, 1'b0}, 1'b1);
        send_byte(8'h00, {2'b11, 1'b0, 8'h00, 1'b0}, 1'b1);
        wait_drain();

        // Odd parity, one stop bit
        sel = 2;
        repeat (2) @(negedge clk);
        send_byte(8'h07, {1'b1, 1'b0, 8'h07, 1'b0}, 1'b1);
        send_byte(8'h80, {1'b1, 1'b0, 8'h80, 1'b0}, 1'b1);
        send_byte(8'h03, {1'b1, 1'b1, 8'h03, 1'b0}, 1'b1);
        wait_drain();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("done_pulses", done_cnt, n_pushed);
        check("aborted_frames", n_abort, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
